// File: rtl/bibp_pkg.sv
// bibp_pkg: opcode and FSM state constants shared by the sequential ALU
package bibp_pkg;
  typedef logic [2:0] islem_t;
  localparam islem_t TOPLA       = 3'd0;
  localparam islem_t CIKAR       = 3'd1;
  localparam islem_t SOLA_KAYDIR = 3'd2;
  localparam islem_t SAGA_KAYDIR = 3'd3;
  localparam islem_t SOLA_DONDUR = 3'd4;
  localparam islem_t SAGA_DONDUR = 3'd5;
  localparam islem_t CARP        = 3'd6;
  localparam islem_t KARSILASTIR = 3'd7;
  localparam logic [1:0] BOSTA   = 2'd0;
  localparam logic [1:0] HESAPLA = 2'd1;
  localparam logic [1:0] BITTI   = 2'd2;
endpackage

// File: rtl/bibp_adim.sv
// bibp_adim: one shift, rotate or shift-add step of the sequential ALU
module bibp_adim
  import bibp_pkg::*;
#(
  parameter int UZUNLUK = 4
) (
  input  logic [2:0]           islem,
  input  logic [UZUNLUK*2-1:0] deger,
  input  logic [UZUNLUK*2-1:0] ek,
  input  logic                 carp_bit,
  output logic [UZUNLUK*2-1:0] yeni
);
  localparam int W = UZUNLUK;
  always_comb
    yeni = islem == SOLA_KAYDIR ? deger << 1 :
           islem == SAGA_KAYDIR ? {{W{1'b0}}, 1'b0, deger[W-1:1]} :
           islem == SOLA_DONDUR ? {{W{1'b0}}, deger[W-2:0], deger[W-1]} :
           islem == SAGA_DONDUR ? {{W{1'b0}}, deger[0], deger[W-1:1]} :
           islem == CARP        ? deger + (carp_bit ? ek : '0) :
                                  deger;
endmodule

// File: rtl/bibp_sirali.sv
// bibp_sirali: multi-cycle ALU with valid/ready handshake on both sides
module bibp_sirali
  import bibp_pkg::*;
#(
  parameter int UZUNLUK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UZUNLUK*2+2:0] buyruk,
  input  logic                 gecerli,
  output logic                 hazir,
  output logic [UZUNLUK*2-1:0] sonuc,
  output logic                 sonuc_gecerli,
  input  logic                 sonuc_hazir
);
  localparam int W = UZUNLUK;
  localparam int W2 = 2 * W;
  localparam int SW = $clog2(W2) + 1;
  localparam int LW = $clog2(W);
  logic [1:0] durum;
  logic [2:0] op, y_op;
  logic [W-1:0] a, b, y_a, y_b;
  logic [W2-1:0] acc, mc, yeni, val, son;
  logic [W+SW-1:0] bx;
  logic [SW-1:0] kalan, k;
  logic [W:0] toplam, fark;
  logic bos;
  assign y_op = buyruk[W2+2:W2];
  assign y_a = buyruk[W2-1:W];
  assign y_b = buyruk[W-1:0];
  assign bx = {{SW{1'b0}}, y_b};
  assign hazir = (durum == BOSTA) && !rst;
  // step count k; zero steps still costs one HESAPLA cycle (C = max(k,1))
  always_comb
    k = y_op == SOLA_KAYDIR ? (bx > (W+SW)'(W2) ? SW'(W2) : bx[SW-1:0]) :
        y_op == SAGA_KAYDIR ? (bx > (W+SW)'(W) ? SW'(W) : bx[SW-1:0]) :
        (y_op == SOLA_DONDUR || y_op == SAGA_DONDUR) ? {{(SW-LW){1'b0}}, y_b[LW-1:0]} :
        y_op == CARP ? SW'(W) : '0;
  bibp_adim #(.UZUNLUK(UZUNLUK)) u_adim (
    .islem(op), .deger(acc), .ek(mc), .carp_bit(b[0]), .yeni(yeni)
  );
  assign toplam = {1'b0, a} + {1'b0, b};
  assign fark = {1'b0, a} - {1'b0, b};
  assign val = bos ? acc : yeni;
  always_comb
    son = op == TOPLA ? W2'(toplam) :
          op == CIKAR ? W2'(fark) :
          op == KARSILASTIR ? W2'({a > b, a == b}) : val;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum <= BOSTA;
      op <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      mc <= '0;
      kalan <= '0;
      bos <= 1'b0;
      sonuc <= '0;
      sonuc_gecerli <= 1'b0;
    end else if (durum == BOSTA) begin
      if (gecerli) begin
        op <= y_op;
        a <= y_a;
        b <= y_b;
        acc <= y_op == CARP ? '0 : {{W{1'b0}}, y_a};
        mc <= {{W{1'b0}}, y_a};
        kalan <= k == '0 ? '0 : k - 1'b1;
        bos <= k == '0;
        durum <= HESAPLA;
      end
    end else if (durum == HESAPLA) begin
      acc <= val;
      mc <= mc << 1;
      b <= b >> 1;
      if (kalan == '0) begin
        sonuc <= son;
        sonuc_gecerli <= 1'b1;
        durum <= BITTI;
      end else
        kalan <= kalan - 1'b1;
    end else if (sonuc_hazir) begin
      sonuc_gecerli <= 1'b0;
      durum <= BOSTA;
    end
  end
endmodule
